// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU execute-stage units: the binary32 operand
// width, the position of the sign bit and the sign-injection op encoding.
// No ports; import with `import fpu_pkg::*;`.
// ---------------------------------------------------------------------------
package fpu_pkg;

  localparam int FP_W    = 32;
  localparam int FP_SIGN = 31;

  // Sign-injection modes. 2'b11 is deliberately left unnamed: it is the
  // illegal encoding and is caught by the default branch of the decoders.
  typedef enum logic [1:0] {
    SGNJ_J = 2'b00,
    SGNJ_N = 2'b01,
    SGNJ_X = 2'b10
  } sgnj_op_e;

endpackage

// File: rtl/fsgnj_core.sv
// ---------------------------------------------------------------------------
// fsgnj_core
// Purely combinational sign injection. The magnitude of a is passed through
// untouched and the sign is derived from b according to op. Shared by the
// registered fsgnj_unit and the FPU bypass path.
//
// Ports:
//   a       in  W  source of exponent/mantissa (and sign for FSGNJX)
//   b       in  W  source of the sign bit
//   op      in  2  mode (see fpu_pkg::sgnj_op_e); 2'b11 is illegal
//   c       out W  result
//   illegal out 1  op was the illegal encoding; c is a unchanged then
// ---------------------------------------------------------------------------
module fsgnj_core
  import fpu_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [1:0]   op,
  output logic [W-1:0] c,
  output logic         illegal
);

  // Start from a copy of a so that the illegal op naturally yields a
  // unchanged; only the sign bit is ever overwritten.
  always_comb begin
    c       = a;
    illegal = 1'b0;
    case (op)
      SGNJ_J:  c[W-1] = b[W-1];
      SGNJ_N:  c[W-1] = ~b[W-1];
      SGNJ_X:  c[W-1] = a[W-1] ^ b[W-1];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/fsgnj_unit.sv
// ---------------------------------------------------------------------------
// fsgnj_unit
// Registered single-precision sign-injection unit with valid/ready on both
// sides. One output register stage holds the result and the illegal flag;
// latency is one cycle and a new op may be accepted in the same cycle the
// held result drains.
//
// Ports:
//   clk       in  1  clock, rising edge
//   rst       in  1  asynchronous active-high reset
//   in_valid  in  1  a, b, op valid this cycle
//   in_ready  out 1  unit accepts an op this cycle
//   op        in  2  sign-injection mode
//   a         in  W  magnitude source
//   b         in  W  sign source
//   out_valid out 1  c and illegal hold a result
//   out_ready in  1  consumer takes the result this cycle
//   c         out W  result
//   illegal   out 1  result came from the illegal op encoding
// ---------------------------------------------------------------------------
module fsgnj_unit
  import fpu_pkg::*;
#(
  parameter int W = FP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] c,
  output logic         illegal
);

  logic [W-1:0] core_c;
  logic         core_illegal;

  logic         valid_q,   valid_d;
  logic [W-1:0] c_q,       c_d;
  logic         illegal_q, illegal_d;
  logic         accept;

  fsgnj_core #(.W(W)) u_core (
    .a       (a),
    .b       (b),
    .op      (op),
    .c       (core_c),
    .illegal (core_illegal)
  );

  // The stage can take a new op whenever it is empty or its current result
  // leaves this cycle, which gives back-to-back throughput.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Next-state: capture on accept, drop valid when the result drains with
  // nothing new behind it, otherwise hold everything (data is kept even
  // when invalid so the output does not toggle needlessly).
  always_comb begin
    valid_d   = valid_q;
    c_d       = c_q;
    illegal_d = illegal_q;
    if (accept) begin
      valid_d   = 1'b1;
      c_d       = core_c;
      illegal_d = core_illegal;
    end else if (out_ready) begin
      valid_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      c_q       <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      c_q       <= c_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = valid_q;
  assign c         = c_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_fsgnj_unit.sv
// ---------------------------------------------------------------------------
// tb_fsgnj_unit
// Scoreboard bench for fsgnj_unit: the driver pushes the reference result
// whenever an op is accepted, the monitor pops and compares whenever a
// result is handed over. Directed cases cover the listed operand patterns,
// backpressure and an asynchronous reset; a random sweep follows.
// ---------------------------------------------------------------------------
module tb_fsgnj_unit;

  typedef struct {
    logic [31:0] c;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] c;
  logic        illegal;

  exp_t sb[$];
  int   tests = 0;
  int   failures = 0;
  int   pops = 0;

  fsgnj_unit #(.W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Reference: magnitude is a modulo 2^31; the sign is chosen arithmetically
  // from the sign values of a and b.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic [1:0] mop);
    exp_t        r;
    int unsigned mag, sa, sb_, s;
    mag = ma % 32'h8000_0000;
    sa  = ma / 32'h8000_0000;
    sb_ = mb / 32'h8000_0000;
    r.ill = 1'b0;
    case (mop)
      2'd0:    s = sb_;
      2'd1:    s = 1 - sb_;
      2'd2:    s = (sa + sb_) % 2;
      default: begin s = sa; r.ill = 1'b1; end
    endcase
    r.c = mag + s * 32'h8000_0000;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs shortly after the falling edge, then at the
  // sample point (negedge+3) record the accept, if any, into the scoreboard.
  task automatic applyStimulus(input logic v, input logic [31:0] ia,
                               input logic [31:0] ib, input logic [1:0] iop,
                               input logic ordy);
    @(negedge clk);
    #1;
    in_valid  = v;
    a         = ia;
    b         = ib;
    op        = iop;
    out_ready = ordy;
    #2;
    if (!rst && in_valid && in_ready) sb.push_back(model(a, b, op));
  endtask

  // Monitor: pops one expected result per handshake at the sample point.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_result", {31'd0, out_valid}, 32'd0);
        end else begin
          e = sb.pop_front();
          pops++;
          checkOutput("sb_c", c, e.c);
          checkOutput("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
        end
      end
    end
  end

  // Single op followed by an idle cycle; the result must be present exactly
  // one cycle after acceptance.
  task automatic directedOp(input string name, input logic [31:0] ia,
                            input logic [31:0] ib, input logic [1:0] iop,
                            input logic [31:0] expC, input logic expIll);
    applyStimulus(1'b1, ia, ib, iop, 1'b1);
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b1);
    checkOutput({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({name, "_c"}, c, expC);
    checkOutput({name, "_illegal"}, {31'd0, illegal}, {31'd0, expIll});
  endtask

  initial begin
    int startPops;
    int n;

    // Reset state.
    #12;
    checkOutput("reset_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_c", c, 32'd0);
    checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b0;

    // Directed operand patterns.
    directedOp("fsgnj_basic", 32'h0780_0000, 32'h81FF_FFFF, 2'b00, 32'h8780_0000, 1'b0);
    directedOp("fsgnj_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'hFFFF_FFFF, 1'b0);
    directedOp("fsgnjn", 32'h0780_0000, 32'h81FF_FFFF, 2'b01, 32'h0780_0000, 1'b0);
    directedOp("fsgnjx", 32'h0780_0000, 32'h81FF_FFFF, 2'b10, 32'h8780_0000, 1'b0);
    directedOp("fsgnjx_neg", 32'hBF80_0000, 32'h8000_0000, 2'b10, 32'h3F80_0000, 1'b0);
    directedOp("nan_pass", 32'h7FC0_0001, 32'h8000_0000, 2'b00, 32'hFFC0_0001, 1'b0);
    directedOp("illegal_op", 32'h1234_5678, 32'hFFFF_FFFF, 2'b11, 32'h1234_5678, 1'b1);

    // Backpressure: hold the result for 3 cycles while junk is offered.
    applyStimulus(1'b1, 32'hBF80_0000, 32'h8000_0000, 2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0, 2'b01, 1'b0);
      checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_c_stable", c, 32'h3F80_0000);
      checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    applyStimulus(1'b1, 32'h7FC0_0001, 32'h8000_0000, 2'b00, 1'b1);
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b1);
    checkOutput("bp_no_bubble_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("bp_second_c", c, 32'hFFC0_0001);

    // Asynchronous reset while a result is held.
    applyStimulus(1'b1, 32'h1234_5678, 32'h0, 2'b11, 1'b0);
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b0);
    checkOutput("pre_rst_illegal", {31'd0, illegal}, 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("async_rst_c", c, 32'd0);
    checkOutput("async_rst_illegal", {31'd0, illegal}, 32'd0);
    sb.delete();
    @(negedge clk);
    #1 rst = 1'b0;
    directedOp("post_rst", 32'h4049_0FDB, 32'h8000_0000, 2'b00, 32'hC049_0FDB, 1'b0);

    // Random sweep at full throughput: one result per cycle.
    n = 4000;
    startPops = pops;
    for (int i = 0; i < n; i++)
      applyStimulus(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b1);
    applyStimulus(1'b0, '0, '0, 2'b00, 1'b1);
    checkOutput("sweep_throughput", pops - startPops, n);

    // Random sweep with random valid/ready.
    for (int i = 0; i < 3000; i++)
      applyStimulus(1'($urandom), $urandom, $urandom, 2'($urandom_range(0, 3)),
                    1'($urandom));

    // Bounded drain.
    for (int i = 0; i < 10 && sb.size() != 0; i++)
      applyStimulus(1'b0, '0, '0, 2'b00, 1'b1);
    checkOutput("drain_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
